// File: rtl/chip8_subroutine_ctrl.sv
// rtl/chip8_subroutine_ctrl.sv - CHIP-8 CALL/RET sequencer driving the Chip8_Stack block
// Moore FSM: pushes PC+PC_STEP on CALL, pops into the PC on RET, tracks depth locally.
module chip8_subroutine_ctrl #(
  parameter int ADDR_W  = 12,
  parameter int DEPTH   = 16,
  parameter int PC_STEP = 2
) (
  input  logic              cpu_clk,
  input  logic              reset,
  input  logic              call_req,
  input  logic              ret_req,
  input  logic [ADDR_W-1:0] call_target,
  input  logic [ADDR_W-1:0] pc_in,
  output logic [1:0]        stk_we,
  output logic [15:0]       stk_writedata,
  input  logic [15:0]       stk_outdata,
  output logic [ADDR_W-1:0] pc_next,
  output logic              pc_load,
  output logic              done,
  output logic [1:0]        err,
  output logic              busy,
  output logic [4:0]        depth
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PUSH,
    S_POP,
    S_POP_WAIT,
    S_LOAD,
    S_FINISH,
    S_ERROR
  } state_t;

  localparam logic [1:0] WE_IDLE = 2'b00;
  localparam logic [1:0] WE_PUSH = 2'b01;
  localparam logic [1:0] WE_POP  = 2'b10;

  localparam logic [1:0] ERR_OK    = 2'b00;
  localparam logic [1:0] ERR_OVF   = 2'b01;
  localparam logic [1:0] ERR_UNF   = 2'b10;
  localparam logic [1:0] ERR_ILLEG = 2'b11;

  localparam logic [4:0]        DEPTH_MAX = 5'(DEPTH);
  localparam logic [ADDR_W-1:0] PC_INC    = ADDR_W'(PC_STEP);

  state_t            state_q, state_d;
  logic [4:0]        depth_q, depth_d;
  logic [ADDR_W-1:0] ret_addr_q, ret_addr_d;
  logic [ADDR_W-1:0] tgt_q, tgt_d;
  logic [1:0]        err_q, err_d;

  // The stack stores 16-bit words; only the PC-width slice is meaningful on return.
  logic stk_hi_unused;
  assign stk_hi_unused = ^stk_outdata[15:ADDR_W];

  always_ff @(posedge cpu_clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      depth_q    <= '0;
      ret_addr_q <= '0;
      tgt_q      <= '0;
      err_q      <= ERR_OK;
    end else begin
      state_q    <= state_d;
      depth_q    <= depth_d;
      ret_addr_q <= ret_addr_d;
      tgt_q      <= tgt_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    depth_d       = depth_q;
    ret_addr_d    = ret_addr_q;
    tgt_d         = tgt_q;
    err_d         = err_q;
    stk_we        = WE_IDLE;
    stk_writedata = '0;
    pc_next       = '0;
    pc_load       = 1'b0;
    done          = 1'b0;
    err           = ERR_OK;

    unique case (state_q)
      S_IDLE: begin
        if (call_req && ret_req) begin
          err_d   = ERR_ILLEG;
          state_d = S_ERROR;
        end else if (call_req) begin
          if (depth_q == DEPTH_MAX) begin
            err_d   = ERR_OVF;
            state_d = S_ERROR;
          end else begin
            // Sum is truncated to ADDR_W, so 0xFFE + 2 wraps to 0x000.
            ret_addr_d = pc_in + PC_INC;
            tgt_d      = call_target;
            state_d    = S_PUSH;
          end
        end else if (ret_req) begin
          if (depth_q == '0) begin
            err_d   = ERR_UNF;
            state_d = S_ERROR;
          end else begin
            state_d = S_POP;
          end
        end
      end

      S_PUSH: begin
        stk_we        = WE_PUSH;
        stk_writedata = 16'(ret_addr_q);
        depth_d       = depth_q + 5'd1;
        state_d       = S_FINISH;
      end

      S_FINISH: begin
        pc_next = tgt_q;
        pc_load = 1'b1;
        done    = 1'b1;
        state_d = S_IDLE;
      end

      S_POP: begin
        stk_we  = WE_POP;
        depth_d = depth_q - 5'd1;
        state_d = S_POP_WAIT;
      end

      // Gives the stack one cycle to present the popped word on outdata.
      S_POP_WAIT: begin
        state_d = S_LOAD;
      end

      S_LOAD: begin
        pc_next = stk_outdata[ADDR_W-1:0];
        pc_load = 1'b1;
        done    = 1'b1;
        state_d = S_IDLE;
      end

      S_ERROR: begin
        done    = 1'b1;
        err     = err_q;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy  = (state_q != S_IDLE);
  assign depth = depth_q;

endmodule

// File: tb/tb_chip8_subroutine_ctrl.sv
// tb/tb_chip8_subroutine_ctrl.sv - scoreboard bench for chip8_subroutine_ctrl
// Stimulus pushes expected stack ops and completions; a negedge monitor pops and compares.
module tb_chip8_subroutine_ctrl;

  logic        clk;
  logic        reset;
  logic        call_req;
  logic        ret_req;
  logic [11:0] call_target;
  logic [11:0] pc_in;
  logic [1:0]  stk_we;
  logic [15:0] stk_writedata;
  logic [15:0] stk_outdata;
  logic [11:0] pc_next;
  logic        pc_load;
  logic        done;
  logic [1:0]  err;
  logic        busy;
  logic [4:0]  depth;

  chip8_subroutine_ctrl #(.ADDR_W(12), .DEPTH(16), .PC_STEP(2)) dut (
    .cpu_clk      (clk),
    .reset        (reset),
    .call_req     (call_req),
    .ret_req      (ret_req),
    .call_target  (call_target),
    .pc_in        (pc_in),
    .stk_we       (stk_we),
    .stk_writedata(stk_writedata),
    .stk_outdata  (stk_outdata),
    .pc_next      (pc_next),
    .pc_load      (pc_load),
    .done         (done),
    .err          (err),
    .busy         (busy),
    .depth        (depth)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural Chip8_Stack: registered outdata after a pop, reset alongside the DUT.
  logic [15:0] mem [16];
  logic [4:0]  sp;
  always @(posedge clk) begin
    if (reset) begin
      sp          <= '0;
      stk_outdata <= '0;
    end else if (stk_we == 2'b01) begin
      mem[sp[3:0]] <= stk_writedata;
      sp           <= sp + 5'd1;
    end else if (stk_we == 2'b10) begin
      stk_outdata <= mem[4'(sp - 5'd1)];
      sp          <= sp - 5'd1;
    end
  end

  typedef struct {int we; int wd; int lat;} stk_t;
  typedef struct {int pc_load; int pc_next; int err; int depth; int lat;} done_t;

  stk_t  stk_q[$];
  done_t done_q[$];
  int    exp_ret[$];
  int    exp_depth;
  int    n_cmp;
  int    n_bad;
  int    cyc;
  int    req_cyc;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!reset && !busy && (call_req || ret_req)) req_cyc = cyc;
    if (stk_we != 2'b00) begin
      if (stk_q.size() == 0) begin
        chk("unexpected_stk_we", int'(stk_we), 0);
      end else begin
        stk_t e;
        e = stk_q.pop_front();
        chk("stk_we", int'(stk_we), e.we);
        chk("stk_writedata", int'(stk_writedata), e.wd);
        chk("stk_latency", cyc - req_cyc, e.lat);
      end
    end
    if (done || pc_load) begin
      if (done_q.size() == 0) begin
        chk("unexpected_done", int'(done), 0);
      end else begin
        done_t d;
        d = done_q.pop_front();
        chk("done", int'(done), 1);
        chk("pc_load", int'(pc_load), d.pc_load);
        chk("pc_next", int'(pc_next), d.pc_next);
        chk("err", int'(err), d.err);
        chk("depth", int'(depth), d.depth);
        chk("done_latency", cyc - req_cyc, d.lat);
      end
    end
  end

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (busy) chk("idle_timeout", 1, 0);
  endtask

  task automatic do_call(input int pc, input int tgt, input bit hold);
    if (exp_depth == 16) begin
      done_q.push_back('{0, 0, 1, 16, 1});
    end else begin
      stk_q.push_back('{1, (pc + 2) & 'hFFF, 1});
      exp_ret.push_back((pc + 2) & 'hFFF);
      exp_depth++;
      done_q.push_back('{1, tgt, 0, exp_depth, 2});
    end
    @(posedge clk); #1;
    call_req = 1'b1; pc_in = 12'(pc); call_target = 12'(tgt);
    @(posedge clk); #1;
    if (hold) begin
      @(posedge clk); #1;
    end
    call_req = 1'b0;
    wait_idle();
  endtask

  task automatic do_ret();
    if (exp_depth == 0) begin
      done_q.push_back('{0, 0, 2, 0, 1});
    end else begin
      stk_q.push_back('{2, 0, 1});
      exp_depth--;
      done_q.push_back('{1, exp_ret.pop_back(), 0, exp_depth, 3});
    end
    @(posedge clk); #1;
    ret_req = 1'b1;
    @(posedge clk); #1;
    ret_req = 1'b0;
    wait_idle();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_stk_we"}, int'(stk_we), 0);
    chk({tag, "_stk_writedata"}, int'(stk_writedata), 0);
    chk({tag, "_pc_next"}, int'(pc_next), 0);
    chk({tag, "_pc_load"}, int'(pc_load), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_err"}, int'(err), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_depth"}, int'(depth), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_cmp = 0; n_bad = 0; cyc = 0; req_cyc = 0; exp_depth = 0;
    reset = 1'b1; call_req = 1'b0; ret_req = 1'b0;
    call_target = '0; pc_in = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1;
    reset = 1'b0;

    // Basic call then return: push 0x202, jump 0x300, return to 0x202.
    do_call('h200, 'h300, 1'b0);
    do_ret();

    // Fill the stack, overflow once, then drain in LIFO order.
    for (int k = 0; k < 16; k++) do_call('h200 + 4 * k, 'h400 + k, 1'b0);
    do_call('h280, 'h500, 1'b0);
    for (int j = 0; j < 16; j++) do_ret();

    // Underflow and simultaneous requests.
    do_ret();
    done_q.push_back('{0, 0, 3, 0, 1});
    @(posedge clk); #1;
    call_req = 1'b1; ret_req = 1'b1; pc_in = 12'h222; call_target = 12'h333;
    @(posedge clk); #1;
    call_req = 1'b0; ret_req = 1'b0;
    wait_idle();

    // Request held into a busy cycle is ignored; PC wrap at 0xFFE.
    do_call('h320, 'h654, 1'b1);
    do_call('hFFE, 'h123, 1'b0);

    // Reset during POP_WAIT: pop happens, completion is dropped.
    stk_q.push_back('{2, 0, 1});
    @(posedge clk); #1;
    ret_req = 1'b1;
    @(posedge clk); #1;
    ret_req = 1'b0;
    chk("pop_state_busy", int'(busy), 1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    exp_depth = 0;
    exp_ret.delete();
    @(negedge clk);
    check_reset_outputs("midop_reset");
    repeat (3) @(negedge clk);
    chk("post_reset_done", int'(done), 0);

    // Normal operation resumes after the mid-operation reset.
    do_call('h500, 'h600, 1'b0);
    do_ret();

    repeat (4) @(posedge clk);
    chk("stk_queue_drained", stk_q.size(), 0);
    chk("done_queue_drained", done_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
